// File: rtl/pulse_window_arbiter_if.sv
// rtl/pulse_window_arbiter_if.sv - request/grant/pulse bundle for pulse_window_arbiter
interface pulse_window_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 8
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic [LEN_W-1:0] cfg_len;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] gnt;
    logic             out_pulse;
    logic             busy;
    logic             done;

    modport master (
        output en, req, cfg_len,
        input  pend, gnt, out_pulse, busy, done
    );

    modport slave (
        input  en, req, cfg_len,
        output pend, gnt, out_pulse, busy, done
    );
endinterface

// File: rtl/pulse_window_arbiter.sv
// rtl/pulse_window_arbiter.sv - round-robin owner of a stretched pulse window with guard gap
module pulse_window_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PULSE_CYCLES = 32,
    parameter int GUARD_CYCLES = 2,
    parameter int LEN_W        = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    pulse_window_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GUARD  = 2'd2;

    localparam logic [LEN_W-1:0] DEF_LEN    = LEN_W'(PULSE_CYCLES);
    localparam logic [LEN_W-1:0] GUARD_LAST = (GUARD_CYCLES == 0) ? '0 : LEN_W'(GUARD_CYCLES - 1);

    generate
        if (N_REQ < 2 || PULSE_CYCLES < 1 || PULSE_CYCLES >= 2**LEN_W ||
            GUARD_CYCLES < 0 || GUARD_CYCLES > 2**LEN_W) begin : g_bad_params
            $fatal(1, "pulse_window_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] gnt_q;
    logic             out_q;
    logic             busy_q;
    logic             done_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;

    logic [N_REQ-1:0] cand;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] win_mask;
    logic [PTR_W-1:0] ptr_n;
    logic             grant_now;
    logic [LEN_W-1:0] len_sel;
    logic [N_REQ-1:0] pend_n;
    int               k;

    assign cand = pend_q | bus.req;

    // Scan from ptr with wrap; the first set candidate wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int j = 0; j < N_REQ; j++) begin
            k = (int'(ptr) + j) % N_REQ;
            if (!win_found && cand[k]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(k);
            end
        end
    end

    assign win_mask  = N_REQ'(1) << win_idx;
    assign ptr_n     = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    assign grant_now = (state == S_IDLE) && bus.en && win_found;
    assign len_sel   = (bus.cfg_len == '0) ? DEF_LEN : bus.cfg_len;

    // The grant consumes the winner's trigger; a request that was already pending and
    // is raised again on the grant edge counts as a fresh trigger and stays latched.
    assign pend_n = grant_now ? (((pend_q | bus.req) & ~win_mask) | (pend_q & bus.req & win_mask))
                              : (pend_q | bus.req);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            ptr    <= '0;
            pend_q <= '0;
            gnt_q  <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            len_q  <= '0;
        end else begin
            pend_q <= pend_n;
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        state  <= S_ACTIVE;
                        gnt_q  <= win_mask;
                        out_q  <= 1'b1;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        ptr    <= ptr_n;
                        len_q  <= len_sel;
                        done_q <= (len_sel == LEN_W'(1));
                    end
                end
                S_ACTIVE: begin
                    if (cnt == len_q - LEN_W'(1)) begin
                        gnt_q  <= '0;
                        out_q  <= 1'b0;
                        done_q <= 1'b0;
                        cnt    <= '0;
                        if (GUARD_CYCLES == 0) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_GUARD;
                        end
                    end else begin
                        cnt    <= cnt + LEN_W'(1);
                        // done is registered, so raise it one edge ahead of the last cycle
                        done_q <= (cnt + LEN_W'(2) == len_q);
                    end
                end
                S_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pend      = pend_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_pulse = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
